// File: rtl/universal_d_register.sv
// Universal edge-triggered D register: hold, shift right, shift left and
// parallel load, with a saturating shift counter for serialiser and
// deserialiser use.
module universal_d_register #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ROTATE = 0,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sir,
    input  logic             sil,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] p,
    output logic             so,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    localparam logic [1:0]       MODE_HOLD  = 2'b00;
    localparam logic [1:0]       MODE_RIGHT = 2'b01;
    localparam logic [1:0]       MODE_LEFT  = 2'b10;
    localparam logic [1:0]       MODE_LOAD  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_nxt;
    logic             so_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] count_inc;
    logic             fill_r;
    logic             fill_l;

    // Bit entering the vacated position: recirculated or taken from serial in.
    assign fill_r = (ROTATE != 0) ? q[0]       : sir;
    assign fill_l = (ROTATE != 0) ? q[WIDTH-1] : sil;

    // Saturating increment; shifts past WIDTH still move data but not the count.
    assign count_inc = (count == CNT_MAX) ? count : count + CNT_W'(1);

    // Next-state selection in priority order: enable, clear, then mode.
    always_comb begin
        q_nxt     = q;
        so_nxt    = so;
        count_nxt = count;
        if (en) begin
            if (clr) begin
                q_nxt     = '0;
                so_nxt    = 1'b0;
                count_nxt = '0;
            end else begin
                case (mode)
                    MODE_HOLD: begin
                        q_nxt = q;
                    end
                    MODE_RIGHT: begin
                        so_nxt    = q[0];
                        q_nxt     = {fill_r, q[WIDTH-1:1]};
                        count_nxt = count_inc;
                    end
                    MODE_LEFT: begin
                        so_nxt    = q[WIDTH-1];
                        q_nxt     = {q[WIDTH-2:0], fill_l};
                        count_nxt = count_inc;
                    end
                    MODE_LOAD: begin
                        q_nxt     = d;
                        count_nxt = '0;
                    end
                    default: begin
                        q_nxt = q;
                    end
                endcase
            end
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            so    <= 1'b0;
            count <= '0;
        end else begin
            q     <= q_nxt;
            so    <= so_nxt;
            count <= count_nxt;
        end
    end

    assign p    = ~q;
    assign done = (count == CNT_MAX);

endmodule

// File: tb/tb_universal_d_register.sv
// Bench for universal_d_register: one shift-in instance and one rotating
// instance share stimulus; a scoreboard queue holds the expected state
// after every clock edge and a monitor compares it one step after the edge.
module tb_universal_d_register;

    localparam int unsigned W = 8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [7:0] d;
    logic       sir;
    logic       sil;

    logic [7:0] q0, p0, q1, p1;
    logic       so0, so1, done0, done1;
    logic [3:0] count0, count1;

    universal_d_register #(.WIDTH(8), .ROTATE(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .d(d),
        .sir(sir), .sil(sil), .q(q0), .p(p0), .so(so0), .count(count0), .done(done0)
    );

    universal_d_register #(.WIDTH(8), .ROTATE(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .d(d),
        .sir(sir), .sil(sil), .q(q1), .p(p1), .so(so1), .count(count1), .done(done1)
    );

    typedef struct {
        int q[2];
        int so[2];
        int cnt[2];
    } exp_t;

    exp_t exp_q[$];

    int m_q[2];
    int m_so[2];
    int m_cnt[2];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Reference model from the behavioural rules, kept as plain integers.
    task automatic model_edge(input logic r, input logic e, input logic c,
                              input logic [1:0] m, input logic [7:0] dd,
                              input logic si_r, input logic si_l);
        for (int k = 0; k < 2; k++) begin
            int nq;
            if (!r) begin
                m_q[k] = 0; m_so[k] = 0; m_cnt[k] = 0;
            end else if (e) begin
                if (c) begin
                    m_q[k] = 0; m_so[k] = 0; m_cnt[k] = 0;
                end else if (m == 2'd3) begin
                    m_q[k] = int'(dd); m_cnt[k] = 0;
                end else if (m == 2'd1) begin
                    nq = (m_q[k] / 2) + 128 * ((k == 1) ? (m_q[k] % 2) : int'(si_r));
                    m_so[k] = m_q[k] % 2;
                    m_q[k] = nq;
                    m_cnt[k] = (m_cnt[k] + 1 > int'(W)) ? int'(W) : m_cnt[k] + 1;
                end else if (m == 2'd2) begin
                    nq = ((m_q[k] * 2) % 256) + ((k == 1) ? (m_q[k] / 128) : int'(si_l));
                    m_so[k] = m_q[k] / 128;
                    m_q[k] = nq;
                    m_cnt[k] = (m_cnt[k] + 1 > int'(W)) ? int'(W) : m_cnt[k] + 1;
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, predict, then wait for the rising edge.
    task automatic step(input logic r, input logic e, input logic c,
                        input logic [1:0] m, input logic [7:0] dd,
                        input logic si_r, input logic si_l);
        exp_t x;
        @(negedge clk);
        rst_n = r; en = e; clr = c; mode = m; d = dd; sir = si_r; sil = si_l;
        model_edge(r, e, c, m, dd, si_r, si_l);
        x.q = m_q; x.so = m_so; x.cnt = m_cnt;
        exp_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare both instances against the oldest prediction.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("q0",     32'(q0),     32'(x.q[0]));
            chk("p0",     32'(p0),     32'(~x.q[0] & 255));
            chk("so0",    32'(so0),    32'(x.so[0]));
            chk("count0", 32'(count0), 32'(x.cnt[0]));
            chk("done0",  32'(done0),  32'(x.cnt[0] == int'(W)));
            chk("q1",     32'(q1),     32'(x.q[1]));
            chk("p1",     32'(p1),     32'(~x.q[1] & 255));
            chk("so1",    32'(so1),    32'(x.so[1]));
            chk("count1", 32'(count1), 32'(x.cnt[1]));
            chk("done1",  32'(done1),  32'(x.cnt[1] == int'(W)));
        end
    end

    initial begin
        logic [7:0] so_seq;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'b00; d = '0; sir = 1'b0; sil = 1'b0;
        for (int k = 0; k < 2; k++) begin m_q[k] = 0; m_so[k] = 0; m_cnt[k] = 0; end
        step(0, 0, 0, 2'b00, 8'h00, 0, 0);

        // Asynchronous reset between edges with A5 loaded.
        step(1, 1, 0, 2'b11, 8'hA5, 0, 0);
        chk("preload_q0", 32'(q0), 32'h0000_00A5);
        #1;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin m_q[k] = 0; m_so[k] = 0; m_cnt[k] = 0; end
        #1;
        chk("rst_async_q0",    32'(q0),     32'h0);
        chk("rst_async_p0",    32'(p0),     32'hFF);
        chk("rst_async_count", 32'(count0), 32'h0);
        chk("rst_async_done",  32'(done0),  32'h0);
        step(0, 1, 0, 2'b11, 8'hFF, 0, 0);
        chk("rst_edge_hold_q0", 32'(q0), 32'h0);

        // Load then hold.
        step(1, 1, 0, 2'b11, 8'h3C, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 2'b00, 8'h00, 0, 0);
        chk("hold_q0", 32'(q0), 32'h3C);
        chk("hold_p0", 32'(p0), 32'hC3);

        // Serialise right with SIR=1.
        step(1, 1, 0, 2'b11, 8'h96, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 2'b01, 8'h00, 1, 0);
            so_seq[i] = so0;
        end
        chk("ser_so_seq", 32'(so_seq), 32'h96);
        chk("ser_q0",     32'(q0),     32'hFF);
        chk("ser_count",  32'(count0), 32'd8);
        chk("ser_done",   32'(done0),  32'd1);
        step(1, 1, 0, 2'b01, 8'h00, 1, 0);
        chk("ser_sat_count", 32'(count0), 32'd8);

        // Rotate left.
        step(1, 1, 0, 2'b11, 8'h81, 0, 0);
        step(1, 1, 0, 2'b10, 8'h00, 0, 0);
        chk("rot_q1",  32'(q1),  32'h03);
        chk("rot_so1", 32'(so1), 32'd1);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 2'b10, 8'h00, 0, 0);
        chk("rot8_q1",   32'(q1),    32'h81);
        chk("rot8_done", 32'(done1), 32'd1);

        // Priority: clear beats load; disable masks clear.
        step(1, 1, 1, 2'b11, 8'hFF, 0, 0);
        chk("clr_q0", 32'(q0), 32'h0);
        step(1, 1, 0, 2'b11, 8'h5A, 0, 0);
        step(1, 0, 1, 2'b11, 8'hFF, 0, 0);
        chk("en0_hold_q0", 32'(q0), 32'h5A);

        // Deserialise left.
        step(1, 1, 1, 2'b00, 8'h00, 0, 0);
        step(1, 1, 0, 2'b10, 8'h00, 0, 1);
        step(1, 1, 0, 2'b10, 8'h00, 0, 0);
        step(1, 1, 0, 2'b10, 8'h00, 0, 1);
        step(1, 1, 0, 2'b10, 8'h00, 0, 1);
        chk("des_q0",    32'(q0),     32'h0B);
        chk("des_count", 32'(count0), 32'd4);
        chk("des_done",  32'(done0),  32'd0);
        step(1, 1, 0, 2'b11, 8'h00, 0, 0);
        chk("des_load_count", 32'(count0), 32'd0);

        // Randomised traffic, shift-heavy so the counter saturates often.
        for (int i = 0; i < 600; i++) begin
            logic       r, e, c;
            logic [1:0] m;
            r = ($urandom_range(0, 39) != 0);
            e = ($urandom_range(0, 7) != 0);
            c = ($urandom_range(0, 11) == 0);
            m = ($urandom_range(0, 9) < 7) ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 3));
            step(r, e, c, m, 8'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
